// File: rtl/fb_arbiter.sv
// Framebuffer SRAM arbiter: fixed beam-timed video fetch slot,
// leftover RAM cycles go to a req/ack host port.
module fb_arbiter #(
  parameter int HSTART = 64,
  parameter int VSTART = 48,
  parameter int ACT_W  = 256,
  parameter int ACT_H  = 192,
  parameter int AW     = 13
) (
  input  logic          clk7,
  input  logic          rst_n,
  input  logic [8:0]    hc,
  input  logic [8:0]    vc,
  output logic [7:0]    vid_byte,
  output logic          vid_valid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic          host_ack,
  output logic [7:0]    host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  localparam logic [9:0] L_H0 = 10'(HSTART - 8);
  localparam logic [9:0] L_H1 = 10'(HSTART + ACT_W - 8);
  localparam logic [9:0] L_V0 = 10'(VSTART);
  localparam logic [9:0] L_V1 = 10'(VSTART + ACT_H);

  typedef enum logic {
    S_IDLE,
    S_DONE
  } state_t;

  state_t        r_state;
  logic          r_ack;
  logic [7:0]    r_rdata;
  logic          r_we;
  logic          r_vpend;
  logic          r_vvalid;
  logic [7:0]    r_vbyte;

  logic [9:0]    w_hc10;
  logic [9:0]    w_vc10;
  logic          w_vslot;
  logic [9:0]    w_row;
  logic [9:0]    w_col;
  logic [AW-1:0] w_vaddr;
  logic          w_host_go;

  assign w_hc10 = {1'b0, hc};
  assign w_vc10 = {1'b0, vc};

  // Wrap of the beam counters needs no state: the range compare covers it
  assign w_vslot = (w_vc10 >= L_V0) && (w_vc10 < L_V1) &&
                   (w_hc10 >= L_H0) && (w_hc10 < L_H1) &&
                   (hc[2:0] == 3'd0);

  assign w_row   = w_vc10 - L_V0;
  assign w_col   = (w_hc10 - L_H0) >> 3;
  assign w_vaddr = AW'(32'(w_row) * (ACT_W / 8) + 32'(w_col));

  assign w_host_go = (r_state == S_IDLE) && host_req && !w_vslot;

  assign mem_addr  = w_vslot ? w_vaddr : host_addr;
  assign mem_we    = rst_n && w_host_go && host_we;
  assign mem_wdata = host_wdata;

  always_ff @(posedge clk7) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_rdata <= 8'h00;
      r_we    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_host_go) begin
            r_we    <= host_we;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_ack   <= 1'b1;
          if (!r_we) r_rdata <= mem_rdata;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // RAM data for a slot arrives one cycle after its address
  always_ff @(posedge clk7) begin
    if (!rst_n) begin
      r_vpend  <= 1'b0;
      r_vvalid <= 1'b0;
      r_vbyte  <= 8'h00;
    end else begin
      r_vpend  <= w_vslot;
      r_vvalid <= r_vpend;
      if (r_vpend) r_vbyte <= mem_rdata;
    end
  end

  assign host_ack   = r_ack;
  assign host_rdata = r_rdata;
  assign vid_valid  = r_vvalid;
  assign vid_byte   = r_vbyte;

endmodule
